hilo_muldiv_unit: RTL and testbench

Parametrised, multi-cycle multiply/divide unit that owns the Hi/Lo register pair for the Execute stage. It replaces the single-cycle Hi/Lo path with an iterative engine that produces one result bit per cycle. It supports signed and unsigned multiply, divide, multiply-add and multiply-subtract at any operand width. A Stall output freezes the pipeline while an operation is in flight; mthi/mtlo writes and Hi/Lo reads go through the same block.

---
 rtl/hilo_muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative Hi/Lo multiply/divide unit for the Execute stage: one result bit per cycle,
// with signed fixup, multiply-accumulate, and mthi/mtlo access to the Hi/Lo pair.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t             state;
  logic [2:0]         op_r;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   hi, lo, rem;
  logic [2*WIDTH-1:0] acc, prod;
  logic [CNT_W-1:0]   cnt;

  logic               op_valid, accept, signed_in, div_in, div_run;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [WIDTH:0]     add_sum, part_rem, diff;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign op_valid  = ~(Op[2] & Op[1]);
  assign accept    = Start & op_valid & ((state == IDLE) | (state == DONE));
  assign Stall     = Busy | accept;
  assign signed_in = (Op == OP_MULT) | (Op == OP_DIV) | (Op == OP_MADD) | (Op == OP_MSUB);
  assign div_in    = (Op == OP_DIV) | (Op == OP_DIVU);
  assign div_run   = (op_r == OP_DIV) | (op_r == OP_DIVU);
  assign neg_a_in  = signed_in & A[WIDTH-1];
  assign neg_b_in  = signed_in & B[WIDTH-1];
  assign a_mag_in  = neg_a_in ? -A : A;
  assign b_mag_in  = neg_b_in ? -B : B;
  assign Hi_out    = hi;
  assign Lo_out    = lo;

  // Multiply keeps the multiplier in prod's low half; divide shifts the dividend out of it
  // while quotient bits shift in from the right.
  assign add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : '0)};
  assign part_rem = {rem, prod[WIDTH-1]};
  assign diff     = part_rem - {1'b0, mag_b};

  always_comb begin
    mul_res = (sign_a ^ sign_b) ? -prod : prod;
    res_hi  = mul_res[2*WIDTH-1:WIDTH];
    res_lo  = mul_res[WIDTH-1:0];
    case (op_r)
      OP_MADD: {res_hi, res_lo} = acc + mul_res;
      OP_MSUB: {res_hi, res_lo} = acc - mul_res;
      OP_DIV, OP_DIVU: begin
        if (mag_b == '0) begin
          res_hi = sign_a ? -mag_a : mag_a;
          res_lo = '1;
        end else begin
          res_hi = sign_a ? -rem : rem;
          res_lo = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      hi     <= '0;
      lo     <= '0;
      rem    <= '0;
      acc    <= '0;
      prod   <= '0;
      cnt    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      if (mthi & ~Busy & ~accept) hi <= WriteData;
      if (mtlo & ~Busy & ~accept) lo <= WriteData;
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (accept) begin
            state  <= RUN;
            Busy   <= 1'b1;
            op_r   <= Op;
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            mag_a  <= a_mag_in;
            mag_b  <= b_mag_in;
            acc    <= {hi, lo};
            prod   <= {{WIDTH{1'b0}}, (div_in ? a_mag_in : b_mag_in)};
            rem    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (div_run) begin
            rem  <= diff[WIDTH] ? part_rem[WIDTH-1:0] : diff[WIDTH-1:0];
            prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            prod <= {add_sum, prod[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          hi    <= res_hi;
          lo    <= res_lo;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit: a 32-bit instance for arithmetic, mt writes and
// reset, and an 8-bit instance for latency and back-to-back issue.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, start32, mthi32, mtlo32, busy32, done32, stall32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;
  logic        rst8, start8, mthi8, mtlo8, busy8, done8, stall8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  int checks = 0;
  int failures = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut32 (
    .Clk(clk), .Reset(rst32), .Start(start32), .Op(op32), .A(a32), .B(b32),
    .mthi(mthi32), .mtlo(mtlo32), .WriteData(wd32), .Busy(busy32), .Done(done32),
    .Stall(stall32), .Hi_out(hi32), .Lo_out(lo32)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst8), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .mthi(mthi8), .mtlo(mtlo8), .WriteData(wd8), .Busy(busy8), .Done(done8),
    .Stall(stall8), .Hi_out(hi8), .Lo_out(lo8)
  );

  // Issues one op on the 32-bit unit and waits (bounded) for Done. Optionally injects a
  // second Start plus an mtlo write in cycle inj, both of which must be ignored.
  task automatic do_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int dcyc, output int stall_err,
                         output logic [31:0] hi_mid, output logic [31:0] lo_mid);
    @(negedge clk);
    op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    #1;
    stall_err = stall32 ? 0 : 1;
    dcyc = -1;
    hi_mid = hi32;
    lo_mid = lo32;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      mtlo32 = 1'b0;
      if (c == inj) begin
        start32 = 1'b1; op32 = 3'b001; a32 = 32'd2; b32 = 32'd2;
        mtlo32 = 1'b1; wd32 = 32'h0000DEAD;
      end
      #1;
      if (c == 5) begin hi_mid = hi32; lo_mid = lo32; end
      if (done32) begin dcyc = c; break; end
      if (!stall32) stall_err++;
    end
    start32 = 1'b0;
    mtlo32 = 1'b0;
  endtask

  task automatic test_reset();
    rst32 = 1'b1; rst8 = 1'b1;
    start32 = 0; mthi32 = 0; mtlo32 = 0; op32 = '0; a32 = '0; b32 = '0; wd32 = '0;
    start8 = 0; mthi8 = 0; mtlo8 = 0; op8 = '0; a8 = '0; b8 = '0; wd8 = '0;
    repeat (2) @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;
    #1;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy32); end
    checks++; if (done32 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done32); end
    checks++; if (stall32 !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", stall32); end
    checks++; if (hi32 !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi32); end
    checks++; if (lo32 !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo32); end
    checks++;
    if ({busy8, done8, stall8, hi8, lo8} !== 19'h0) begin
      failures++; $display("[TB] FAIL reset_w8: got %b%b%b %h %h expected all zero", busy8, done8, stall8, hi8, lo8);
    end
  endtask

  task automatic test_multu();
    int d, se; logic [31:0] hm, lm;
    do_op32(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, d, se, hm, lm);
    checks++; if (d !== 34) begin failures++; $display("[TB] FAIL multu_latency: got %0d expected 34", d); end
    checks++; if (se !== 0) begin failures++; $display("[TB] FAIL multu_stall_run: got %0d low cycles expected 0", se); end
    checks++; if (stall32 !== 1'b0) begin failures++; $display("[TB] FAIL multu_stall_done: got %b expected 0", stall32); end
    checks++; if (hm !== 32'h0 || lm !== 32'h0) begin failures++; $display("[TB] FAIL multu_hold_run: got %h %h expected 0 0", hm, lm); end
    checks++; if (hi32 !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi32); end
    checks++; if (lo32 !== 32'h00000001) begin failures++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo32); end
  endtask

  task automatic test_signed_mul();
    int d, se; logic [31:0] hm, lm;
    do_op32(3'b000, 32'hFFFFFFFD, 32'd7, -1, d, se, hm, lm);
    checks++;
    if (hi32 !== 32'hFFFFFFFF || lo32 !== 32'hFFFFFFEB) begin
      failures++; $display("[TB] FAIL mult_neg3x7: got %h_%h expected ffffffff_ffffffeb", hi32, lo32);
    end
  endtask

  task automatic test_divide();
    int d, se; logic [31:0] hm, lm;
    do_op32(3'b010, 32'hFFFFFFF9, 32'd2, -1, d, se, hm, lm);
    checks++;
    if (lo32 !== 32'hFFFFFFFD || hi32 !== 32'hFFFFFFFF) begin
      failures++; $display("[TB] FAIL div_neg7by2: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi32, lo32);
    end
    do_op32(3'b011, 32'd100, 32'd7, -1, d, se, hm, lm);
    checks++;
    if (lo32 !== 32'd14 || hi32 !== 32'd2) begin
      failures++; $display("[TB] FAIL divu_100by7: got hi=%h lo=%h expected hi=00000002 lo=0000000e", hi32, lo32);
    end
    do_op32(3'b011, 32'd7, 32'd0, -1, d, se, hm, lm);
    checks++;
    if (hi32 !== 32'h00000007 || lo32 !== 32'hFFFFFFFF) begin
      failures++; $display("[TB] FAIL divu_by_zero: got hi=%h lo=%h expected hi=00000007 lo=ffffffff", hi32, lo32);
    end
    do_op32(3'b010, 32'hFFFFFFFB, 32'd0, -1, d, se, hm, lm);
    checks++;
    if (hi32 !== 32'hFFFFFFFB || lo32 !== 32'hFFFFFFFF) begin
      failures++; $display("[TB] FAIL div_by_zero: got hi=%h lo=%h expected hi=fffffffb lo=ffffffff", hi32, lo32);
    end
    do_op32(3'b010, 32'h80000000, 32'hFFFFFFFF, -1, d, se, hm, lm);
    checks++;
    if (lo32 !== 32'h80000000 || hi32 !== 32'h0) begin
      failures++; $display("[TB] FAIL div_overflow: got hi=%h lo=%h expected hi=00000000 lo=80000000", hi32, lo32);
    end
  endtask

  task automatic test_mt_madd();
    int d, se; logic [31:0] hm, lm;
    @(negedge clk); mthi32 = 1'b1; wd32 = 32'h0;
    @(negedge clk); mthi32 = 1'b0; mtlo32 = 1'b1; wd32 = 32'hFFFFFFFF;
    #1;
    checks++; if (hi32 !== 32'h0) begin failures++; $display("[TB] FAIL mthi_write: got %h expected 00000000", hi32); end
    @(negedge clk); mtlo32 = 1'b0;
    #1;
    checks++; if (lo32 !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL mtlo_write: got %h expected ffffffff", lo32); end
    do_op32(3'b100, 32'd1, 32'd1, -1, d, se, hm, lm);
    checks++;
    if (hi32 !== 32'd1 || lo32 !== 32'd0) begin
      failures++; $display("[TB] FAIL madd_carry: got %h_%h expected 00000001_00000000", hi32, lo32);
    end
    do_op32(3'b101, 32'd1, 32'd1, -1, d, se, hm, lm);
    checks++;
    if (hi32 !== 32'd0 || lo32 !== 32'hFFFFFFFF) begin
      failures++; $display("[TB] FAIL msub_borrow: got %h_%h expected 00000000_ffffffff", hi32, lo32);
    end
  endtask

  task automatic test_busy_ignore();
    int d, se; logic [31:0] hm, lm;
    do_op32(3'b001, 32'd5, 32'd6, 3, d, se, hm, lm);
    checks++; if (d !== 34) begin failures++; $display("[TB] FAIL busy_latency: got %0d expected 34", d); end
    checks++;
    if (hi32 !== 32'd0 || lo32 !== 32'd30) begin
      failures++; $display("[TB] FAIL busy_ignore_result: got %h_%h expected 00000000_0000001e", hi32, lo32);
    end
    @(negedge clk); #1;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("[TB] FAIL busy_no_second_op: got %b expected 0", busy32); end
  endtask

  task automatic test_reserved_op();
    @(negedge clk); start32 = 1'b1; op32 = 3'b110; a32 = 32'd3; b32 = 32'd3;
    #1;
    checks++; if (stall32 !== 1'b0) begin failures++; $display("[TB] FAIL reserved_stall: got %b expected 0", stall32); end
    @(negedge clk); start32 = 1'b0;
    #1;
    checks++;
    if (busy32 !== 1'b0 || lo32 !== 32'd30) begin
      failures++; $display("[TB] FAIL reserved_ignored: got busy=%b lo=%h expected busy=0 lo=0000001e", busy32, lo32);
    end
  endtask

  task automatic test_reset_midrun();
    int d, se; logic [31:0] hm, lm;
    @(negedge clk); start32 = 1'b1; op32 = 3'b001; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); @(negedge clk); start32 = 1'b0;
    end
    rst32 = 1'b1;
    @(posedge clk); @(negedge clk);
    rst32 = 1'b0;
    #1;
    checks++;
    if (hi32 !== 32'h0 || lo32 !== 32'h0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_midrun: got hi=%h lo=%h busy=%b done=%b expected all zero", hi32, lo32, busy32, done32);
    end
    do_op32(3'b001, 32'd3, 32'd4, -1, d, se, hm, lm);
    checks++; if (d !== 34) begin failures++; $display("[TB] FAIL post_reset_accept: got %0d expected 34", d); end
    checks++; if (lo32 !== 32'd12) begin failures++; $display("[TB] FAIL post_reset_result: got %h expected 0000000c", lo32); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic b2b_stall = 1'b0;
    logic [7:0] h1 = '0, l1 = '0;
    @(negedge clk); start8 = 1'b1; op8 = 3'b001; a8 = 8'hFF; b8 = 8'hFF;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      start8 = 1'b0;
      #1;
      if (done8 && d1 < 0) begin
        d1 = c; h1 = hi8; l1 = lo8;
        start8 = 1'b1; op8 = 3'b001; a8 = 8'h0F; b8 = 8'h03;
        #1;
        b2b_stall = stall8;
      end else if (done8) begin
        d2 = c;
        break;
      end
    end
    start8 = 1'b0;
    checks++; if (d1 !== 10) begin failures++; $display("[TB] FAIL w8_latency: got %0d expected 10", d1); end
    checks++;
    if (h1 !== 8'hFE || l1 !== 8'h01) begin
      failures++; $display("[TB] FAIL w8_multu: got %h_%h expected fe_01", h1, l1);
    end
    checks++; if (b2b_stall !== 1'b1) begin failures++; $display("[TB] FAIL w8_b2b_stall: got %b expected 1", b2b_stall); end
    checks++; if (d2 !== 20) begin failures++; $display("[TB] FAIL w8_b2b_latency: got %0d expected 20", d2); end
    checks++;
    if (hi8 !== 8'h00 || lo8 !== 8'h2D) begin
      failures++; $display("[TB] FAIL w8_b2b_result: got %h_%h expected 00_2d", hi8, lo8);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed_mul();
    test_divide();
    test_mt_madd();
    test_busy_ignore();
    test_reserved_op();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
